// File: rtl/vram_write_queue.sv
// -----------------------------------------------------------------------------
// vram_write_queue
//
// Writer side of the VRAM port shared with the foreground/background renderers.
// Byte-write and fill requests from the CPU bus adapter are accepted over a
// valid/ready handshake, buffered in a FIFO, and driven onto the VRAM write
// port only while the video timing `writable` window is open. A fill request
// expands into req_len+1 consecutive byte writes of the same value (used to
// clear ranges or park unused objects).
//
// Ports:
//   clk          pixel clock
//   rst          synchronous reset, active-low
//   writable     VRAM write window from video timing
//   req_valid    request present
//   req_ready    queue can accept a request
//   req_addr     start address
//   req_data     byte to write
//   req_fill     1 = fill command, 0 = single write
//   req_len      fill writes req_len+1 bytes (ignored for single writes)
//   vram_we      write strobe, commits on the clk edge
//   vram_address write address
//   vram_data    write data
//   busy         FIFO non-empty or fill in progress
//   pending      FIFO occupancy (entries only, not remaining fill writes)
// -----------------------------------------------------------------------------
module vram_write_queue #(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       writable,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [ADDR_W-1:0]          req_addr,
   input  logic [7:0]                 req_data,
   input  logic                       req_fill,
   input  logic [7:0]                 req_len,
   output logic                       vram_we,
   output logic [ADDR_W-1:0]          vram_address,
   output logic [7:0]                 vram_data,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     pending
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic {IDLE, FILL} state_t;

   state_t              state;
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    count;
   logic [ADDR_W-1:0]   fill_addr;
   logic [7:0]          fill_data;
   logic [7:0]          remaining;

   logic                mem_fill [DEPTH];
   logic [7:0]          mem_len  [DEPTH];
   logic [ADDR_W-1:0]   mem_addr [DEPTH];
   logic [7:0]          mem_data [DEPTH];

   logic                head_fill;
   logic [7:0]          head_len;
   logic [ADDR_W-1:0]   head_addr;
   logic [7:0]          head_data;

   logic                push;
   logic                pop;

   assign head_fill = mem_fill[rd_ptr];
   assign head_len  = mem_len[rd_ptr];
   assign head_addr = mem_addr[rd_ptr];
   assign head_data = mem_data[rd_ptr];

   // Ready depends only on registered occupancy: a full FIFO refuses a push
   // even when the head pops in the same cycle.
   assign req_ready = rst && (count != FULL_CNT);
   assign push      = req_valid && req_ready;
   assign pop       = rst && (state == IDLE) && (count != '0) && writable;

   assign busy      = rst && ((state == FILL) || (count != '0));
   assign pending   = rst ? count : '0;

   // Write port is combinational so the strobe follows `writable` with no lag.
   always_comb begin
      vram_address = head_addr;
      vram_data    = head_data;
      vram_we      = 1'b0;
      if (state == FILL) begin
         vram_address = fill_addr;
         vram_data    = fill_data;
         vram_we      = rst && writable;
      end else begin
         vram_we      = rst && writable && (count != '0);
      end
   end

   // FIFO storage holds data only; it needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_fill[wr_ptr] <= req_fill;
         mem_len[wr_ptr]  <= req_len;
         mem_addr[wr_ptr] <= req_addr;
         mem_data[wr_ptr] <= req_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         fill_addr <= '0;
         fill_data <= '0;
         remaining <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);

         case (state)
            IDLE: begin
               // The popped head already wrote its first byte; the fill
               // registers pick up at the following address.
               if (pop && head_fill && (head_len != 8'd0)) begin
                  fill_addr <= head_addr + ADDR_W'(1);
                  fill_data <= head_data;
                  remaining <= head_len;
                  state     <= FILL;
               end
            end
            FILL: begin
               if (writable) begin
                  fill_addr <= fill_addr + ADDR_W'(1);
                  remaining <= remaining - 8'd1;
                  if (remaining == 8'd1) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vram_write_queue.sv
module tb_vram_write_queue;

   logic        clk;
   logic        rst;
   logic        writable;
   logic        req_valid;
   logic        req_ready;
   logic [11:0] req_addr;
   logic [7:0]  req_data;
   logic        req_fill;
   logic [7:0]  req_len;
   logic        vram_we;
   logic [11:0] vram_address;
   logic [7:0]  vram_data;
   logic        busy;
   logic [4:0]  pending;

   int total;
   int bad;

   vram_write_queue #(.ADDR_W(12), .DEPTH(16)) dut (
      .clk(clk), .rst(rst), .writable(writable),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data),
      .req_fill(req_fill), .req_len(req_len),
      .vram_we(vram_we), .vram_address(vram_address), .vram_data(vram_data),
      .busy(busy), .pending(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one clock edge, then let registered state settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; req_valid = 1'b1; writable = 1'b1;
      req_addr = 12'h123; req_data = 8'h45; req_fill = 1'b0; req_len = 8'd0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready cyc%0d got=%b exp=0", i, req_ready); end
         total++; if (vram_we !== 1'b0) begin bad++; $display("FAIL rst_we cyc%0d got=%b exp=0", i, vram_we); end
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy cyc%0d got=%b exp=0", i, busy); end
         total++; if (pending !== 5'd0) begin bad++; $display("FAIL rst_pending cyc%0d got=%0d exp=0", i, pending); end
         @(posedge clk);
      end
      #1;
      rst = 1'b1; req_valid = 1'b0; writable = 1'b0;
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rel_ready got=%b exp=1", req_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rel_busy got=%b exp=0", busy); end
      step();
   endtask

   task automatic test_queue_drain();
      logic [11:0] ea [3];
      logic [7:0]  ed [3];
      ea[0] = 12'h100; ed[0] = 8'hAA;
      ea[1] = 12'h101; ed[1] = 8'hBB;
      ea[2] = 12'h0FF; ed[2] = 8'hCC;
      writable = 1'b0; req_fill = 1'b0; req_len = 8'd0;
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1; req_addr = ea[i]; req_data = ed[i];
         #1;
         total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL qd_ready%0d got=%b exp=1", i, req_ready); end
         step();
      end
      req_valid = 1'b0;
      #1;
      total++; if (pending !== 5'd3) begin bad++; $display("FAIL qd_pending got=%0d exp=3", pending); end
      total++; if (vram_we !== 1'b0) begin bad++; $display("FAIL qd_we_closed got=%b exp=0", vram_we); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL qd_busy got=%b exp=1", busy); end
      writable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (vram_we !== 1'b1) begin bad++; $display("FAIL qd_we%0d got=%b exp=1", i, vram_we); end
         total++; if (vram_address !== ea[i]) begin bad++; $display("FAIL qd_addr%0d got=%h exp=%h", i, vram_address, ea[i]); end
         total++; if (vram_data !== ed[i]) begin bad++; $display("FAIL qd_data%0d got=%h exp=%h", i, vram_data, ed[i]); end
         step();
         total++; if (pending !== 5'(2 - i)) begin bad++; $display("FAIL qd_pend_after%0d got=%0d exp=%0d", i, pending, 2 - i); end
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL qd_idle_busy got=%b exp=0", busy); end
      total++; if (vram_we !== 1'b0) begin bad++; $display("FAIL qd_idle_we got=%b exp=0", vram_we); end
      writable = 1'b0;
   endtask

   task automatic test_fill_wrap();
      logic [11:0] ea [4];
      logic [7:0]  ed [4];
      ea[0] = 12'hFFF; ed[0] = 8'hFF;
      ea[1] = 12'h000; ed[1] = 8'hFF;
      ea[2] = 12'h001; ed[2] = 8'hFF;
      ea[3] = 12'h040; ed[3] = 8'h11;
      writable = 1'b1;
      req_valid = 1'b1; req_fill = 1'b1; req_addr = 12'hFFE; req_len = 8'd3; req_data = 8'hFF;
      step();
      req_fill = 1'b0; req_addr = 12'h040; req_data = 8'h11; req_len = 8'd0;
      #1;
      total++; if (vram_we !== 1'b1) begin bad++; $display("FAIL fw_we0 got=%b exp=1", vram_we); end
      total++; if (vram_address !== 12'hFFE) begin bad++; $display("FAIL fw_addr0 got=%h exp=ffe", vram_address); end
      total++; if (vram_data !== 8'hFF) begin bad++; $display("FAIL fw_data0 got=%h exp=ff", vram_data); end
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (vram_we !== 1'b1) begin bad++; $display("FAIL fw_we%0d got=%b exp=1", i + 1, vram_we); end
         total++; if (vram_address !== ea[i]) begin bad++; $display("FAIL fw_addr%0d got=%h exp=%h", i + 1, vram_address, ea[i]); end
         total++; if (vram_data !== ed[i]) begin bad++; $display("FAIL fw_data%0d got=%h exp=%h", i + 1, vram_data, ed[i]); end
         step();
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL fw_busy_end got=%b exp=0", busy); end
      total++; if (pending !== 5'd0) begin bad++; $display("FAIL fw_pending_end got=%0d exp=0", pending); end
      writable = 1'b0;
   endtask

   task automatic test_window_pause();
      logic [12:0] pat;
      logic [11:0] exp_addr;
      pat = 13'b1110110100011; // bit i = writable in cycle i
      exp_addr = 12'h100;
      writable = 1'b0;
      req_valid = 1'b1; req_fill = 1'b1; req_addr = 12'h100; req_len = 8'd7; req_data = 8'h5A;
      step();
      req_valid = 1'b0; req_fill = 1'b0;
      for (int i = 0; i < 13; i++) begin
         writable = pat[i];
         #1;
         total++; if (vram_we !== pat[i]) begin bad++; $display("FAIL wp_we%0d got=%b exp=%b", i, vram_we, pat[i]); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL wp_busy%0d got=%b exp=1", i, busy); end
         if (pat[i]) begin
            total++; if (vram_address !== exp_addr) begin bad++; $display("FAIL wp_addr%0d got=%h exp=%h", i, vram_address, exp_addr); end
            total++; if (vram_data !== 8'h5A) begin bad++; $display("FAIL wp_data%0d got=%h exp=5a", i, vram_data); end
            exp_addr = exp_addr + 12'd1;
         end
         step();
      end
      writable = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL wp_busy_end got=%b exp=0", busy); end
      total++; if (exp_addr !== 12'h108) begin bad++; $display("FAIL wp_count got=%h exp=108", exp_addr); end
   endtask

   task automatic test_full();
      writable = 1'b0; req_fill = 1'b0; req_len = 8'd0;
      for (int i = 0; i < 16; i++) begin
         req_valid = 1'b1; req_addr = 12'(i); req_data = 8'(i + 8'h80);
         #1;
         total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL full_ready%0d got=%b exp=1", i, req_ready); end
         step();
      end
      req_addr = 12'h0AA; req_data = 8'h77;
      #1;
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full_ready16 got=%b exp=0", req_ready); end
      total++; if (pending !== 5'd16) begin bad++; $display("FAIL full_pending got=%0d exp=16", pending); end
      step();
      total++; if (pending !== 5'd16) begin bad++; $display("FAIL full_held got=%0d exp=16", pending); end
      writable = 1'b1;
      #1;
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full_nobypass got=%b exp=0", req_ready); end
      total++; if (vram_address !== 12'h000) begin bad++; $display("FAIL full_head got=%h exp=000", vram_address); end
      step();
      writable = 1'b0;
      #1;
      total++; if (pending !== 5'd15) begin bad++; $display("FAIL full_pop1 got=%0d exp=15", pending); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL full_ready_again got=%b exp=1", req_ready); end
      step();
      req_valid = 1'b0;
      #1;
      total++; if (pending !== 5'd16) begin bad++; $display("FAIL full_17th got=%0d exp=16", pending); end
      writable = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         logic [11:0] ea;
         logic [7:0]  ed;
         ea = (i == 16) ? 12'h0AA : 12'(i);
         ed = (i == 16) ? 8'h77 : 8'(i + 8'h80);
         #1;
         total++; if (vram_address !== ea || vram_data !== ed) begin bad++; $display("FAIL full_drain%0d got=%h/%h exp=%h/%h", i, vram_address, vram_data, ea, ed); end
         step();
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_busy_end got=%b exp=0", busy); end
      writable = 1'b0;
   endtask

   task automatic test_reset_mid_fill();
      int writes;
      writes = 0;
      writable = 1'b1;
      req_valid = 1'b1; req_fill = 1'b1; req_addr = 12'h200; req_len = 8'd200; req_data = 8'h33;
      step();
      for (int i = 0; i < 10; i++) begin
         if (i < 4) begin
            req_valid = 1'b1; req_fill = 1'b0; req_addr = 12'(12'h300 + i); req_data = 8'(i);
         end else begin
            req_valid = 1'b0;
         end
         #1;
         total++; if (vram_address !== 12'(12'h200 + i)) begin bad++; $display("FAIL rm_addr%0d got=%h exp=%h", i, vram_address, 12'h200 + i); end
         if (vram_we === 1'b1) writes++;
         step();
      end
      total++; if (writes != 10) begin bad++; $display("FAIL rm_writes got=%0d exp=10", writes); end
      total++; if (pending !== 5'd4) begin bad++; $display("FAIL rm_pending_pre got=%0d exp=4", pending); end
      rst = 1'b0;
      #1;
      total++; if (vram_we !== 1'b0) begin bad++; $display("FAIL rm_we_rst got=%b exp=0", vram_we); end
      total++; if (pending !== 5'd0) begin bad++; $display("FAIL rm_pending_rst got=%0d exp=0", pending); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy_rst got=%b exp=0", busy); end
      step();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++; if (vram_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rm_residual%0d we=%b busy=%b exp=0/0", i, vram_we, busy); end
         step();
      end
      writable = 1'b0;
   endtask

   initial begin
      total = 0; bad = 0;
      test_reset();
      test_queue_drain();
      test_fill_wrap();
      test_window_pause();
      test_full();
      test_reset_mid_fill();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vram_write_queue.md
Name: vram_write_queue

Overview:
- Writer side of the VRAM port that the foreground/background renderers read from (PMF, OBM, etc.).
- Accepts byte-write and fill requests from the CPU bus adapter over a valid/ready handshake, buffers them in a FIFO, and drives them onto the VRAM write port only while the video timing `writable` window is open.
- Fill commands clear or initialise ranges, e.g. parking unused objects with YP=0xFF.

Parameters:
- ADDR_W, 12, VRAM byte-address width (matches VRAM_ADDR_WIDTH).
- DEPTH, 16, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  pixel clock (12.5875 MHz)
- rst  in  1  synchronous reset, active-low
- writable  in  1  VRAM write window from video timing
- req_valid  in  1  request present
- req_ready  out  1  queue can accept a request
- req_addr  in  ADDR_W  start address
- req_data  in  8  byte to write
- req_fill  in  1  1 = fill command, 0 = single write
- req_len  in  8  fill: writes req_len+1 bytes; ignored when req_fill=0
- vram_we  out  1  write strobe; commits on the clk edge
- vram_address  out  ADDR_W  write address
- vram_data  out  8  write data
- busy  out  1  FIFO non-empty or fill in progress
- pending  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=0 at a clk edge):
  - FIFO emptied, state=IDLE, fill registers cleared.
  - While rst=0: req_ready=0, vram_we=0, busy=0, pending=0. vram_address/vram_data are don't-care.
  - Reset mid-fill aborts the fill and discards the remaining writes and all queued entries.
- Handshake:
  - A push occurs on an edge with req_valid && req_ready. The entry stores {fill, len, addr, data}.
  - req_ready = rst && (pending != DEPTH), registered-equivalent.
  - No bypass: a full FIFO refuses a push even when a pop occurs in the same cycle.
  - A pushed entry is visible at the head no earlier than the next cycle.
- Output path:
  - vram_address, vram_data and vram_we are combinational from the head entry or fill registers, so there is zero lag to `writable`.
  - vram_we is never 1 while writable=0.
- State IDLE:
  - Head entry present: vram_address = head.addr, vram_data = head.data, vram_we = writable.
  - On an edge with writable=1, the head pops (pending decrements).
  - If head.fill=1 and head.len != 0: latch fill_addr = head.addr+1 (mod 2^ADDR_W), fill_data = head.data, remaining = head.len; go to FILL.
  - Otherwise (single write, or fill with len=0): stay in IDLE.
  - FIFO empty: vram_we=0.
- State FILL:
  - vram_address = fill_addr, vram_data = fill_data, vram_we = writable.
  - On an edge with writable=1: fill_addr increments with wrap modulo 2^ADDR_W, remaining decrements; if remaining was 1, go to IDLE.
  - writable=0 pauses the fill with no state change and resumes when writable returns.
  - The FIFO is not popped during FILL, but pushes continue.
- Throughput: one VRAM write per writable cycle. Entries are written strictly in FIFO order; a fill completes before the next entry starts.
- busy = (state==FILL) || (pending != 0).
- pending counts FIFO entries only, not remaining fill writes. Simultaneous push and pop leaves pending unchanged.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req_valid=1 -> req_ready=0, vram_we=0, busy=0, pending=0. Release -> req_ready=1 on the first cycle after.
- Queue then drain: writable=0; push (0x100,0xAA), (0x101,0xBB), (0x0FF,0xCC) -> pending=3, vram_we=0. Raise writable -> vram_we=1 for 3 consecutive cycles with addr/data in push order; pending goes 2,1,0; then busy=0.
- Fill with wrap: push fill addr=0xFFE, len=3, data=0xFF with writable=1 -> writes to 0xFFE, 0xFFF, 0x000, 0x001 on 4 consecutive edges, then IDLE. A second queued single write (0x040,0x11) follows on the 5th edge.
- Window pause: fill addr=0x100, len=7 with writable pattern 1,1,0,0,0,1... -> vram_we tracks writable exactly. Addresses 0x100–0x107 each written once, no skips or duplicates; busy=1 throughout.
- Full FIFO: writable=0; 16 pushes -> req_ready=0 after the 16th and the 17th request is held. One writable=1 cycle -> exactly one pop, pending=15, req_ready=1 next cycle, 17th accepted.
- Reset mid-fill: fill len=200 started, 4 entries queued; assert rst=0 after 10 writes -> vram_we=0 immediately, pending=0. After release no residual writes occur even with writable=1.
